// File: rtl/sfp_pkg.sv
// Shared SFP handler definitions: stream frame layout, default FIFO depth and status command codes.
package sfp_pkg;

  localparam int unsigned SFP_DATA_W     = 64;
  localparam int unsigned SFP_FIFO_DEPTH = 16;

  localparam int unsigned ID_MSB   = 63;
  localparam int unsigned ID_LSB   = 62;
  localparam int unsigned CMD_MSB  = 61;
  localparam int unsigned CMD_LSB  = 32;
  localparam int unsigned DATA_MSB = 31;

  typedef enum logic [29:0] {
    CmdSts0 = 30'h200_0000,
    CmdSts1 = 30'h200_0001,
    CmdSts2 = 30'h200_0002,
    CmdSts3 = 30'h200_0003,
    CmdSts4 = 30'h200_0004,
    CmdSts5 = 30'h200_0005,
    CmdSts6 = 30'h200_0006,
    CmdSts7 = 30'h200_0007,
    CmdSts8 = 30'h200_0008
  } sfp_sts_cmd_e;

  function automatic logic [SFP_DATA_W-1:0] sfp_frame(input logic [1:0]  id,
                                                     input logic [29:0] cmd,
                                                     input logic [31:0] data);
    return {id, cmd, data};
  endfunction

endpackage

// File: rtl/sfp_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset so it can map to LUTRAM.
module sfp_fifo_mem #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sfp_tx_stream_fifo.sv
// FWFT AXI-Stream FIFO feeding the SFP TX arbiter; writes into a full FIFO are dropped and counted.
// Optional high-water mark register enabled by defining SFP_FIFO_HWM_EN.
module sfp_tx_stream_fifo
  import sfp_pkg::*;
#(
  parameter int unsigned DATA_W = SFP_DATA_W,
  parameter int unsigned DEPTH  = SFP_FIFO_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [31:0]       o_wr_data_cnt,
  output logic [15:0]       o_drop_cnt,
  output logic              o_overflow,
  output logic [31:0]       o_hwm
);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;
  logic              full, empty, push, pop, drop;
  logic [DATA_W-1:0] rd_data;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign push = s_tvalid & ~full & ~i_clr;
  assign drop = s_tvalid &  full & ~i_clr;
  assign pop  = m_tvalid & m_tready & ~i_clr;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (i_clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef SFP_FIFO_HWM_EN
  logic [ADDR_W:0] hwm_q, hwm_d;

  // cnt_d is already zero under i_clr, but the clear is kept explicit.
  always_comb begin
    hwm_d = hwm_q;
    if (i_clr) begin
      hwm_d = '0;
    end else if (cnt_d > hwm_q) begin
      hwm_d = cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign o_hwm = {{(31 - ADDR_W){1'b0}}, hwm_q};
`else
  assign o_hwm = 32'd0;
`endif

  sfp_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (i_clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (s_tdata),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_data)
  );

  assign s_tready      = ~full;
  assign m_tvalid      = ~empty;
  assign m_tdata       = empty ? '0 : rd_data;
  assign o_wr_data_cnt = {{(31 - ADDR_W){1'b0}}, cnt_q};
  assign o_drop_cnt    = drop_cnt_q;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_sfp_tx_stream_fifo.sv
// Self-checking bench for sfp_tx_stream_fifo: a hand table for the basic order test plus a
// queue scoreboard driving the multi-cycle scenarios.
module tb_sfp_tx_stream_fifo;

  localparam int unsigned DEPTH = 16;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_clr = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [31:0] o_wr_data_cnt;
  logic [15:0] o_drop_cnt;
  logic        o_overflow;
  logic [31:0] o_hwm;

  sfp_tx_stream_fifo #(
    .DATA_W (64),
    .DEPTH  (DEPTH)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clr         (i_clr),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .o_wr_data_cnt (o_wr_data_cnt),
    .o_drop_cnt    (o_drop_cnt),
    .o_overflow    (o_overflow),
    .o_hwm         (o_hwm)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        r;
    logic        c;
    int          exp_cnt;
    logic        exp_valid;
    logic [63:0] exp_data;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  logic [15:0] m_drop = '0;
  logic        m_ovf = 1'b0;
  int          m_hwm = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_hwm();
`ifdef SFP_FIFO_HWM_EN
    return 64'(m_hwm);
`else
    return 64'd0;
`endif
  endfunction

  // Called just after a falling edge: drive, update the model, clock, then compare.
  task automatic cycle(input logic v, input logic [63:0] d, input logic r, input logic c);
    bit m_empty, m_full;
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    i_clr    = c;
    #1;
    m_empty = (sb.size() == 0);
    m_full  = (sb.size() == DEPTH);
    if (c) begin
      sb.delete();
      m_drop = '0;
      m_ovf  = 1'b0;
      m_hwm  = 0;
    end else begin
      if (!m_empty && r) begin
        check("pop_data", m_tdata, sb[0]);
        void'(sb.pop_front());
      end
      if (v && !m_full) sb.push_back(d);
      if (v && m_full) begin
        if (m_drop != 16'hFFFF) m_drop++;
        m_ovf = 1'b1;
      end
      if (sb.size() > m_hwm) m_hwm = sb.size();
    end
    @(posedge i_clk);
    @(negedge i_clk);
    check("count", 64'(o_wr_data_cnt), 64'(sb.size()));
    check("m_tvalid", 64'(m_tvalid), 64'(sb.size() != 0));
    check("s_tready", 64'(s_tready), 64'(sb.size() != DEPTH));
    check("drop_cnt", 64'(o_drop_cnt), 64'(m_drop));
    check("overflow", 64'(o_overflow), 64'(m_ovf));
    check("hwm", 64'(o_hwm), exp_hwm());
    if (sb.size() == 0) check("m_tdata_empty", m_tdata, 64'd0);
    else                check("m_tdata_head", m_tdata, sb[0]);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 64'd1, 1'b0, 1'b0, 1, 1'b1, 64'd1};
    tbl[1] = '{1'b1, 64'd2, 1'b0, 1'b0, 2, 1'b1, 64'd1};
    tbl[2] = '{1'b1, 64'd3, 1'b0, 1'b0, 3, 1'b1, 64'd1};
    tbl[3] = '{1'b0, 64'd0, 1'b1, 1'b0, 2, 1'b1, 64'd2};
    tbl[4] = '{1'b0, 64'd0, 1'b1, 1'b0, 1, 1'b1, 64'd3};
    tbl[5] = '{1'b0, 64'd0, 1'b1, 1'b0, 0, 1'b0, 64'd0};
    tbl[6] = '{1'b0, 64'd0, 1'b1, 1'b0, 0, 1'b0, 64'd0};

    repeat (3) @(negedge i_clk);
    check("reset_cnt", 64'(o_wr_data_cnt), 64'd0);
    check("reset_tvalid", 64'(m_tvalid), 64'd0);
    check("reset_tready", 64'(s_tready), 64'd1);
    check("reset_tdata", m_tdata, 64'd0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // Basic order
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
      check($sformatf("tbl%0d_cnt", i), 64'(o_wr_data_cnt), 64'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_valid", i), 64'(m_tvalid), 64'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_data", i), m_tdata, tbl[i].exp_data);
    end

    // Full and drop
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, 64'(i), 1'b0, 1'b0);
      if (i == 15) check("full_after_16", 64'(s_tready), 64'd0);
    end
    check("drop_is_2", 64'(o_drop_cnt), 64'd2);
    check("ovf_set", 64'(o_overflow), 64'd1);
    for (int i = 0; i < 17; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0);
    check("drained", 64'(o_wr_data_cnt), 64'd0);

    // Simultaneous push/pop at occupancy 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'(32'hA000 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 64'(32'hB000 + i), 1'b1, 1'b0);
      check("occ5_hold", 64'(o_wr_data_cnt), 64'd5);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0);

    // Wrap-around at occupancy 2
    for (int i = 0; i < 40; i++) cycle(1'b1, 64'(100 + i), (i >= 2), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0);
    check("wrap_final_cnt", 64'(o_wr_data_cnt), 64'd0);

    // Clear at occupancy 7 with 3 drops
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 19; i++) cycle(1'b1, 64'(32'hC000 + i), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0);
    check("pre_clr_cnt", 64'(o_wr_data_cnt), 64'd7);
    check("pre_clr_drop", 64'(o_drop_cnt), 64'd3);
    cycle(1'b1, 64'hDEAD, 1'b1, 1'b1);
    check("clr_cnt", 64'(o_wr_data_cnt), 64'd0);
    check("clr_drop", 64'(o_drop_cnt), 64'd0);
    check("clr_ovf", 64'(o_overflow), 64'd0);
    check("clr_tvalid", 64'(m_tvalid), 64'd0);
    cycle(1'b1, 64'h1234, 1'b0, 1'b0);
    check("post_clr_head", m_tdata, 64'h1234);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-burst at occupancy 9
    cycle(1'b0, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b1, 64'(32'hE000 + i), 1'b0, 1'b0);
    check("pre_rst_cnt", 64'(o_wr_data_cnt), 64'd9);
`ifdef SFP_FIFO_HWM_EN
    check("pre_rst_hwm", 64'(o_hwm), 64'd9);
`endif
    s_tvalid = 1'b1;
    s_tdata  = 64'hE009;
    #2 i_rst = 1'b0;
    #1;
    check("arst_cnt", 64'(o_wr_data_cnt), 64'd0);
    check("arst_tvalid", 64'(m_tvalid), 64'd0);
    check("arst_tdata", m_tdata, 64'd0);
    check("arst_tready", 64'(s_tready), 64'd1);
    check("arst_drop", 64'(o_drop_cnt), 64'd0);
    check("arst_ovf", 64'(o_overflow), 64'd0);
    check("arst_hwm", 64'(o_hwm), 64'd0);
    sb.delete();
    m_drop = '0;
    m_ovf  = 1'b0;
    m_hwm  = 0;
    @(negedge i_clk);
    i_rst = 1'b1;
    cycle(1'b1, 64'h5555, 1'b0, 1'b0);
    cycle(1'b0, 64'd0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
